// File: rtl/nand_sweep_tester_pkg.sv
// Shared types and constants for the 4-input NAND sweep tester.
// Vector width follows NUM_VECTORS; err_cnt is one bit wider so a full count of 16 fits.
package nand_sweep_tester_pkg;

    localparam int NUM_VECTORS = 16;
    localparam int VEC_W       = $clog2(NUM_VECTORS);
    localparam int ERR_W       = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Golden response of a 4-input NAND for one input vector.
    function automatic logic nand_expect(input logic [VEC_W-1:0] v);
        return ~&v;
    endfunction

endpackage

// File: rtl/nand_sweep_tester_hold_timer.sv
// Hold timer: counts cycles from 0 while clear is low and flags the last cycle of a hold.
// The count wraps through clear on expire, so a new hold starts from 0 on the next cycle.
module hold_timer #(
    parameter int HOLD_CYCLES = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic expire
);

    localparam int CNT_W = $clog2(HOLD_CYCLES);

    logic [CNT_W-1:0] hold_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (clear) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
        end
    end

    assign expire = (hold_cnt == CNT_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/nand_sweep_tester.sv
// Sweeps all 16 input vectors into a 4-input NAND, holds each for HOLD_CYCLES,
// samples the response at the end of each hold and reports a mismatch map.
//
// state | meaning
// IDLE  | waiting for start; results from the last sweep are held
// DRIVE | vec driven on outA..outD, response checked at end of each hold
// DONE  | one-cycle completion; done pulses, pass/err_cnt/fail_vec are final
module nand_sweep_tester
    import nand_sweep_tester_pkg::*;
#(
    parameter int HOLD_CYCLES = 50
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   inG,
    output logic                   outA,
    output logic                   outB,
    output logic                   outC,
    output logic                   outD,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ERR_W-1:0]       err_cnt,
    output logic [NUM_VECTORS-1:0] fail_vec
);

    state_t                 state, state_nxt;
    logic [VEC_W-1:0]       vec, vec_nxt;
    logic [VEC_W-1:0]       drive, drive_nxt;
    logic [ERR_W-1:0]       err_nxt;
    logic [NUM_VECTORS-1:0] fail_nxt;
    logic                   pass_nxt, busy_nxt, done_nxt;
    logic                   expire, timer_clear, mismatch;

    assign timer_clear = (state != DRIVE) || expire;

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (timer_clear),
        .expire(expire)
    );

    assign mismatch = (inG != nand_expect(vec));

    always_comb begin
        state_nxt = state;
        vec_nxt   = vec;
        err_nxt   = err_cnt;
        fail_nxt  = fail_vec;
        pass_nxt  = pass;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DRIVE;
                    vec_nxt   = '0;
                    err_nxt   = '0;
                    fail_nxt  = '0;
                end
            end
            DRIVE: begin
                if (expire) begin
                    if (mismatch) begin
                        err_nxt       = err_cnt + ERR_W'(1);
                        fail_nxt[vec] = 1'b1;
                    end
                    // pass is loaded together with the move to DONE so it is valid alongside done
                    if (vec == VEC_W'(NUM_VECTORS - 1)) begin
                        state_nxt = DONE;
                        pass_nxt  = (err_nxt == '0);
                    end else begin
                        vec_nxt = vec + VEC_W'(1);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state itself.
        busy_nxt  = (state_nxt != IDLE);
        done_nxt  = (state_nxt == DONE);
        drive_nxt = (state_nxt == DRIVE) ? vec_nxt : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            vec      <= '0;
            drive    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_vec <= '0;
        end else begin
            state    <= state_nxt;
            vec      <= vec_nxt;
            drive    <= drive_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            pass     <= pass_nxt;
            err_cnt  <= err_nxt;
            fail_vec <= fail_nxt;
        end
    end

    assign outA = drive[3];
    assign outB = drive[2];
    assign outC = drive[1];
    assign outD = drive[0];

endmodule

// File: tb/tb_nand_sweep_tester.sv
// Bench for nand_sweep_tester with HOLD_CYCLES=4: table-driven fault cases, random
// fault maps against a popcount model, and hand-written restart/reset sequences.
module tb_nand_sweep_tester;

    localparam int HOLD   = 4;
    localparam int NV     = 16;
    localparam int DONE_AT = NV * HOLD + 1;

    logic        clk = 1'b0;
    logic        rst_n, start, inG;
    logic        outA, outB, outC, outD, busy, done, pass;
    logic [4:0]  err_cnt;
    logic [15:0] fail_vec;

    int          mode;
    logic [15:0] mask;
    logic [3:0]  cur;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    nand_sweep_tester #(.HOLD_CYCLES(HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .inG     (inG),
        .outA    (outA),
        .outB    (outB),
        .outC    (outC),
        .outD    (outD),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err_cnt (err_cnt),
        .fail_vec(fail_vec)
    );

    // NAND under test: mode 1 = stuck at 1, mode 2 = stuck at 0, else good NAND with per-vector flips.
    assign cur = {outA, outB, outC, outD};
    always_comb begin
        inG = 1'b0;
        case (mode)
            1:       inG = 1'b1;
            2:       inG = 1'b0;
            default: inG = (~&cur) ^ mask[cur];
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Starts a sweep and follows it to its done pulse; returns the cycle of done
    // (1 = first cycle after the capturing edge) and whether the vector order was right.
    task automatic run_sweep(input int repulse, input bit hold_start,
                             output int done_cyc, output bit order_ok);
        int         cyc;
        logic [3:0] exp_v;
        order_ok = 1'b1;
        done_cyc = -1;
        start = 1'b1;
        @(negedge clk);
        cyc = 1;
        if (!hold_start) start = 1'b0;
        while (cyc <= 200) begin
            if (done) begin
                done_cyc = cyc;
                if (cur !== 4'h0 || busy !== 1'b1) order_ok = 1'b0;
                break;
            end
            if (cyc <= NV * HOLD) begin
                exp_v = 4'((cyc - 1) / HOLD);
                if (cur !== exp_v || busy !== 1'b1) order_ok = 1'b0;
            end
            if (cyc == repulse) start = 1'b1;
            else if (!hold_start) start = 1'b0;
            @(negedge clk);
            cyc++;
        end
    endtask

    typedef struct {
        int          mode;
        logic [15:0] mask;
        logic [4:0]  exp_err;
        logic [15:0] exp_fail;
        logic        exp_pass;
    } case_t;

    case_t tbl[5];

    initial begin
        int   dc;
        bit   ok;
        bit   seen_done;
        logic [15:0] rmask;

        tbl[0] = '{0, 16'h0000, 5'd0,  16'h0000, 1'b1};
        tbl[1] = '{1, 16'h0000, 5'd1,  16'h8000, 1'b0};
        tbl[2] = '{2, 16'h0000, 5'd15, 16'h7FFF, 1'b0};
        tbl[3] = '{0, 16'h0001, 5'd1,  16'h0001, 1'b0};
        tbl[4] = '{0, 16'hA5A5, 5'd8,  16'hA5A5, 1'b0};

        rst_n = 1'b0; start = 1'b0; mode = 0; mask = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err",  32'(err_cnt), 32'd0);
        check("rst_fail", 32'(fail_vec), 32'd0);
        check("rst_outs", 32'(cur), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            mode = tbl[i].mode;
            mask = tbl[i].mask;
            run_sweep(0, 1'b0, dc, ok);
            check($sformatf("t%0d_done_cyc", i), 32'(dc), 32'(DONE_AT));
            check($sformatf("t%0d_order", i), 32'(ok), 32'd1);
            check($sformatf("t%0d_err", i), 32'(err_cnt), 32'(tbl[i].exp_err));
            check($sformatf("t%0d_fail", i), 32'(fail_vec), 32'(tbl[i].exp_fail));
            check($sformatf("t%0d_pass", i), 32'(pass), 32'(tbl[i].exp_pass));
            @(negedge clk);
            check($sformatf("t%0d_done_1cyc", i), 32'({done, busy}), 32'd0);
            mode = 0;
            mask = 16'hFFFF;
            repeat (5) @(negedge clk);
            check($sformatf("t%0d_hold_err", i), 32'(err_cnt), 32'(tbl[i].exp_err));
            check($sformatf("t%0d_hold_fail", i), 32'(fail_vec), 32'(tbl[i].exp_fail));
        end

        for (int i = 0; i < 6; i++) begin
            rmask = 16'($urandom);
            if (i == 0) rmask = 16'hFFFF;
            mode = 0;
            mask = rmask;
            repeat ($urandom_range(0, 7)) @(negedge clk);
            run_sweep(0, 1'b0, dc, ok);
            check($sformatf("r%0d_done_cyc", i), 32'(dc), 32'(DONE_AT));
            check($sformatf("r%0d_err", i), 32'(err_cnt), 32'($countones(rmask)));
            check($sformatf("r%0d_fail", i), 32'(fail_vec), 32'(rmask));
            check($sformatf("r%0d_pass", i), 32'(pass), 32'(rmask == 16'h0));
            @(negedge clk);
        end

        // start re-pulsed mid-sweep must neither restart nor clear results
        mode = 0; mask = 16'h0003;
        run_sweep(20, 1'b0, dc, ok);
        check("repulse_done_cyc", 32'(dc), 32'(DONE_AT));
        check("repulse_order", 32'(ok), 32'd1);
        check("repulse_err", 32'(err_cnt), 32'd2);
        check("repulse_fail", 32'(fail_vec), 32'h0003);
        @(negedge clk);

        // passing sweep so that a later reset has a set pass to clear
        mask = 16'h0000;
        run_sweep(0, 1'b0, dc, ok);
        check("pre_rst_pass", 32'(pass), 32'd1);
        @(negedge clk);

        // reset for one edge at cycle 30 of a sweep
        mask = 16'h0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        check("mid_err", 32'(err_cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_no_edge_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
        check("abort_err",  32'(err_cnt), 32'd0);
        check("abort_fail", 32'(fail_vec), 32'd0);
        check("abort_outs", 32'(cur), 32'd0);
        seen_done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);

        // start held high restarts on the first IDLE cycle after DONE
        mask = 16'h0000;
        run_sweep(0, 1'b1, dc, ok);
        check("held_done_cyc", 32'(dc), 32'(DONE_AT));
        @(negedge clk);
        check("held_idle_gap", 32'({busy, done}), 32'd0);
        @(negedge clk);
        check("held_restart", 32'(busy), 32'd1);
        start = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 200 && !seen_done; c++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("held_second_done", 32'(seen_done), 32'd1);
        check("held_second_pass", 32'(pass), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/nand_sweep_tester.md
NAND_SWEEP_TESTER -- requirements
Module: nand_sweep_tester

Interface
REQ-001 The block SHALL use one clock and one synchronous, active-low reset.
REQ-002 Parameter HOLD_CYCLES, default 50, SHALL set the number of clock cycles each input vector is held; legal range is 2..1024.
REQ-003 Port clk  input  1  SHALL be the rising-edge clock for all state.
REQ-004 Port rst_n  input  1  SHALL be the synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 Port start  input  1  SHALL be the sweep-request strobe, sampled only in IDLE.
REQ-006 Port inG  input  1  SHALL be the response of the 4-input NAND under test.
REQ-007 Ports outA, outB, outC, outD  output  1 each  SHALL drive the NAND inputs, with outA the MSB and outD the LSB of the current vector.
REQ-008 Port busy  output  1  SHALL be high while a sweep is in progress.
REQ-009 Port done  output  1  SHALL be a one-cycle completion pulse.
REQ-010 Port pass  output  1  SHALL be the held result of the last sweep: 1 means zero mismatches.
REQ-011 Port err_cnt  output  5  SHALL be the held mismatch count of the last sweep, 0..16.
REQ-012 Port fail_vec  output  16  SHALL be the held mismatch map: bit n is set when vector n failed.

Function
REQ-013 The FSM SHALL have three states: IDLE, DRIVE, DONE.
REQ-014 In IDLE: start=1 SHALL move to DRIVE and set vec=0, hold_cnt=0, err_cnt=0, fail_vec=0.
REQ-015 In IDLE: start=0 SHALL hold IDLE.
REQ-016 In DRIVE: hold_cnt SHALL increment every cycle.
REQ-017 In DRIVE: {outA,outB,outC,outD} SHALL equal vec, registered.
REQ-018 In DRIVE, when hold_cnt==HOLD_CYCLES-1, inG SHALL be sampled and compared against expected = ~&vec.
REQ-019 On a mismatch, err_cnt SHALL increment by 1 and fail_vec[vec] SHALL be set on the same edge.
REQ-020 At the end of each hold (hold_cnt==HOLD_CYCLES-1): if vec<15, vec SHALL increment and hold_cnt SHALL clear; if vec==15, the FSM SHALL move to DONE.
REQ-021 In DONE: done=1 for exactly one cycle, pass SHALL load (err_cnt==0), and the FSM SHALL return to IDLE on the next edge.
REQ-022 The DONE cycle SHALL be 16*HOLD_CYCLES+1 cycles after the edge that captured start.
REQ-023 busy SHALL be 1 in DRIVE and DONE, and 0 in IDLE.
REQ-024 start SHALL be ignored while busy=1, with no restart and no result clearing.
REQ-025 start held high SHALL begin a new sweep on the first IDLE cycle after DONE.
REQ-026 outA..outD SHALL be 0 in IDLE and DONE.
REQ-027 err_cnt, fail_vec and pass SHALL hold their values until the next accepted start.
REQ-028 vec SHALL NOT wrap past 15.
REQ-029 err_cnt SHALL saturate at 16 by construction, with no overflow.

Reset
REQ-030 While rst_n=0 at a clock edge: state=IDLE, vec=0, hold_cnt=0, outA..outD=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0.
REQ-031 Reset mid-sweep SHALL abort the sweep with no done pulse and clear all results.
REQ-032 No output SHALL change without a clock edge, including on reset assertion.

Structure
REQ-033 A shared package SHALL hold: the state enum (IDLE, DRIVE, DONE), NUM_VECTORS=16, and the err_cnt width constant.
REQ-034 The hold counter SHALL be a sub-module hold_timer, with ports clk, rst_n, clear, expire, parameterised by HOLD_CYCLES, and width derived via $clog2(HOLD_CYCLES).
REQ-035 Expected-value generation SHALL be combinational; all outputs SHALL be registered.

Verification
REQ-036 HOLD_CYCLES=4, correct NAND model, start pulsed -> done at cycle 65 after capture; err_cnt=0, fail_vec=16'h0000, pass=1.
REQ-037 Same setup -> outD toggles every 4 cycles, outC every 8, outB every 16, outA every 32; the bench SHALL check the order 0000..1111.
REQ-038 inG stuck at 1 -> err_cnt=1, fail_vec=16'h8000, pass=0.
REQ-039 inG stuck at 0 -> err_cnt=15, fail_vec=16'h7FFF, pass=0.
REQ-040 start re-pulsed at cycle 20 of a sweep -> no effect, done still at cycle 65; then rst_n=0 for 1 cycle at cycle 30 of a new sweep -> outputs at reset values next edge, no done pulse.
